// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, opcode field, fetch FSM state.
// Latency: n/a (types only).
// Backpressure: n/a.
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [5:0]  opcode_t;

  // Opcode that stops instruction fetch until a redirect arrives.
  localparam opcode_t HALT = 6'b111111;

  localparam word_t WORD_BYTES = 32'd4;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  // Sequential fetch address; wraps modulo 2^32.
  function automatic word_t next_pc(input word_t pc);
    return pc + WORD_BYTES;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch stage bundle: icache request/response, hazard controls, IF/ID outputs.
// Latency: n/a (wiring only).
// Backpressure: stall freezes the fetch stage; redirect squashes IF/ID.
interface fetch_stage_if;
  import cpu_types_pkg::*;

  logic  ihit;
  word_t imemload;
  logic  stall;
  logic  redirect;
  word_t redirect_pc;
  logic  imemREN;
  word_t imemaddr;
  word_t ifid_instr;
  word_t ifid_pc;
  word_t ifid_npc;
  logic  ifid_valid;
  logic  fetch_halted;

  // Fetch stage side: issues icache requests and drives IF/ID.
  modport master (
    input  ihit, imemload, stall, redirect, redirect_pc,
    output imemREN, imemaddr, ifid_instr, ifid_pc, ifid_npc, ifid_valid, fetch_halted
  );

  // Environment side: icache, hazard unit and decode stage.
  modport slave (
    output ihit, imemload, stall, redirect, redirect_pc,
    input  imemREN, imemaddr, ifid_instr, ifid_pc, ifid_npc, ifid_valid, fetch_halted
  );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register with flush (bubble), hold and load controls.
// Latency: 1 cycle from load to outputs.
// Backpressure: hold keeps contents; flush wins over hold and load.
module if_id_reg
  import cpu_types_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  logic  flush,
  input  logic  hold,
  input  word_t instr_in,
  input  word_t pc_in,
  input  word_t npc_in,
  output word_t instr,
  output word_t pc,
  output word_t npc,
  output logic  valid
);

  // Bubble keeps pc/npc so downstream sees a stable address for the NOP.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr <= '0;
      pc    <= '0;
      npc   <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      instr <= '0;
      valid <= 1'b0;
    end else if (load && !hold) begin
      instr <= instr_in;
      pc    <= pc_in;
      npc   <= npc_in;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, RUN/HALTED FSM and IF/ID register.
// Latency: 1 cycle from ihit to IF/ID valid; PC advances on the same edge.
// Backpressure: stall holds PC, FSM and IF/ID; a miss inserts bubbles.
module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter word_t   PC_INIT = 32'h0000_0000,
  parameter opcode_t HALT_OP = HALT
) (
  input logic         CLK,
  input logic         RST,
  fetch_stage_if.master bus
);

  fetch_state_t state_q, state_d;
  word_t        pc_q, pc_d, pc_plus4;
  logic         ifid_load, ifid_flush, ifid_hold;
  word_t        ifid_instr, ifid_pc, ifid_npc;
  logic         ifid_valid;

  assign pc_plus4 = next_pc(pc_q);

  // Next PC/state and IF/ID controls; priority redirect > stall > ihit > idle.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    ifid_hold  = 1'b0;
    if (bus.redirect) begin
      // Also covers a speculative HALT: fetch restarts at the target.
      pc_d       = bus.redirect_pc & ~32'h3;
      ifid_flush = 1'b1;
      state_d    = RUN;
    end else if (bus.stall) begin
      // Any ihit this cycle is dropped; the request stays up and refetches.
      ifid_hold = 1'b1;
    end else if (state_q == RUN) begin
      if (bus.ihit) begin
        ifid_load = 1'b1;
        if (bus.imemload[31:26] == HALT_OP) begin
          state_d = HALTED;
        end else begin
          pc_d = pc_plus4;
        end
      end else begin
        ifid_flush = 1'b1;
      end
    end else begin
      ifid_flush = 1'b1;
    end
  end

  // PC and FSM state registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RUN;
      pc_q    <= PC_INIT;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  if_id_reg u_if_id (
    .clk      (CLK),
    .rst      (RST),
    .load     (ifid_load),
    .flush    (ifid_flush),
    .hold     (ifid_hold),
    .instr_in (bus.imemload),
    .pc_in    (pc_q),
    .npc_in   (pc_plus4),
    .instr    (ifid_instr),
    .pc       (ifid_pc),
    .npc      (ifid_npc),
    .valid    (ifid_valid)
  );

  assign bus.imemREN      = (state_q == RUN);
  assign bus.fetch_halted = (state_q == HALTED);
  assign bus.imemaddr     = pc_q;
  assign bus.ifid_instr   = ifid_instr;
  assign bus.ifid_pc      = ifid_pc;
  assign bus.ifid_npc     = ifid_npc;
  assign bus.ifid_valid   = ifid_valid;

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter PC_INIT, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter HALT_OP, default 6'b111111, is the opcode that stops fetching; it comes from cpu_types_pkg.
REQ-003 CLK  in  1  is the single clock; all state updates on the rising edge.
REQ-004 RST  in  1  is the reset; it is synchronous and active-high.
REQ-005 ihit  in  1  means the icache returns a valid instruction this cycle.
REQ-006 imemload  in  32  is the instruction word, valid when ihit=1.
REQ-007 stall  in  1  is the hazard hold; it freezes the PC and IF/ID.
REQ-008 redirect  in  1  means a taken branch or jump is resolved downstream; it squashes IF/ID.
REQ-009 redirect_pc  in  32  is the redirect target; bits [1:0] are ignored.
REQ-010 imemREN  out  1  is the icache read enable.
REQ-011 imemaddr  out  32  is the fetch address, equal to the PC register.
REQ-012 ifid_instr  out  32  is the latched instruction and drives the decode stage instruction input.
REQ-013 ifid_pc  out  32  is the address of ifid_instr.
REQ-014 ifid_npc  out  32  is ifid_pc+4, used for JAL link and branch targets.
REQ-015 ifid_valid  out  1  is 1 when ifid_instr is a real instruction and 0 for a bubble.
REQ-016 fetch_halted  out  1  is 1 while the FSM is in HALTED.

Function
REQ-017 The FSM SHALL have two states: RUN and HALTED.
REQ-018 In RUN, imemREN SHALL be 1; in HALTED, imemREN SHALL be 0.
REQ-019 Per-cycle update priority SHALL be redirect > stall > ihit > idle.
REQ-020 On redirect: PC<=redirect_pc[31:2] with [1:0] forced to 00; IF/ID<=bubble; state<=RUN. Any ihit in the same cycle is discarded.
REQ-021 On stall without redirect: PC, IF/ID and state SHALL hold. The icache request stays asserted, and an ihit in that cycle is dropped and refetched later.
REQ-022 On RUN with ihit and no stall or redirect: IF/ID<={imemload, PC, PC+4, valid=1}; PC<=PC+4.
REQ-023 On RUN with no ihit (miss in progress) and no stall: PC SHALL hold and IF/ID<=bubble.
REQ-024 A bubble SHALL be ifid_instr=32'h0 (SLL r0 NOP), ifid_valid=0, with ifid_pc and ifid_npc held.
REQ-025 Halt detection: when a latched imemload[31:26]==HALT_OP, the HALT word itself SHALL enter IF/ID with valid=1, the PC SHALL hold, and the next state SHALL be HALTED.
REQ-026 In HALTED without stall, IF/ID SHALL take a bubble each cycle; a stall SHALL still hold IF/ID.
REQ-027 A redirect while HALTED means the HALT was speculative: RUN SHALL resume at redirect_pc.
REQ-028 PC+4 SHALL wrap modulo 2^32, so 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-029 imemaddr SHALL change in the same cycle as the PC register; the icache SHALL tolerate an address change during a miss.

Reset
REQ-030 While RST=1 at a clock edge, the block SHALL load: PC=PC_INIT, state=RUN, ifid_instr=0, ifid_pc=0, ifid_npc=0, ifid_valid=0.
REQ-031 After reset, imemREN SHALL be 1 and fetch_halted SHALL be 0.
REQ-032 RST SHALL override redirect, stall and ihit in the same cycle, including mid-miss and while HALTED.

Structure
REQ-033 cpu_types_pkg SHALL hold word_t, opcode_t/HALT, and a new fetch_state_t enum {RUN, HALTED}.
REQ-034 The IF/ID register SHALL be sub-module if_id_reg (inputs: load, flush, hold); the PC and FSM stay in fetch_stage.

Verification
REQ-035 Reset then ihit=1 every cycle with words 0x00221820, 0x8C430004: imemaddr sequence 0,4,8; ifid_pc sequence 0,4; ifid_npc=4 then 8.
REQ-036 ihit low for 3 cycles at PC=0x10, then high: imemaddr stays 0x10, 3 bubbles (valid=0), then instr at 0x10 latched and PC=0x14.
REQ-037 stall=1 and ihit=1 for 2 cycles at PC=0x20: PC and IF/ID unchanged; after release, instr at 0x20 latched once.
REQ-038 redirect=1, redirect_pc=0x103, stall=1 and ihit=1 together: PC=0x100, ifid_valid=0 on the next cycle.
REQ-039 Fetch 0xFC000000 at 0x40: IF/ID holds the HALT word with valid=1, imemREN=0, fetch_halted=1, bubbles after; redirect to 0x80 -> RUN, imemaddr=0x80.
REQ-040 PC_INIT=0xFFFFFFFC with ihit=1: next imemaddr=0x0. RST pulse mid-miss: PC=PC_INIT and ifid_valid=0 the next cycle.
